// File: rtl/key_event_pkg.sv
// Shared types for the key event scheduler: per-key FSM states and the queued event record.
// Latency: none (types and helpers only).
// Backpressure: n/a. Optional field: KEY_RELEASE_EVENT_EN adds the release flag to key_event_t.
package key_event_pkg;

  // Widest key index an event can carry (supports up to 256 keys).
  localparam int unsigned KEY_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } key_state_t;

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    logic                 rpt;
`ifdef KEY_RELEASE_EVENT_EN
    logic                 rel;
`endif
  } key_event_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue; state changes on the falling clock edge.
// Latency: a push at edge N is visible at the head right after edge N.
// Backpressure: pop on pop_i when non-empty; push into a full queue without a pop is dropped and flagged.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  key_event_t data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output key_event_t data_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_event_t    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, do_push, do_pop;

  // Decide pop/push/drop; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop_i & ~empty;
    do_push = push_i & (~full | do_pop);
    ovf_d   = push_i & ~do_push;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, occupancy and storage update; storage is cleared so the head reads zero after reset.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (do_push) mem_q[wr_q] <= data_i;
    end
  end

  assign valid_o    = ~empty;
  assign data_o     = mem_q[rd_q];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/key_event_scheduler.sv
// Scans NUM_KEYS debounced keys one per cycle, emitting press/auto-repeat events into a FWFT queue.
// Latency: an event pushed at falling edge N is at the queue head right after edge N.
// Backpressure: o_Valid/i_Ready handshake; events arriving at a full queue are dropped with o_Overflow.
// Optional: KEY_RELEASE_EVENT_EN adds o_Release and pushes an event when a held key is let go.
module key_event_scheduler
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS      = 8,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic [NUM_KEYS-1:0]         i_Keys,
  output logic                        o_Valid,
  input  logic                        i_Ready,
  output logic [$clog2(NUM_KEYS)-1:0] o_Key,
  output logic                        o_Repeat,
  output logic                        o_Overflow
`ifdef KEY_RELEASE_EVENT_EN
  ,
  output logic                        o_Release
`endif
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int CW = $clog2(max_i(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [KW-1:0] PTR_LAST    = KW'(NUM_KEYS - 1);

  logic [KW-1:0]       ptr_q, ptr_d;
  key_state_t          st_q  [NUM_KEYS];
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] prev_q;

  key_state_t    cur_st, st_d;
  logic [CW-1:0] cur_cnt, cnt_d;
  logic          lvl, fell, push, push_rpt, pop;
  key_event_t    push_ev, head_ev;

  // Next state for the scanned key only; outside IDLE the previous level is always 1,
  // so a falling level is the release condition.
  always_comb begin
    lvl      = i_Keys[ptr_q];
    cur_st   = st_q[ptr_q];
    cur_cnt  = cnt_q[ptr_q];
    fell     = prev_q[ptr_q] & ~lvl;
    ptr_d    = (ptr_q == PTR_LAST) ? '0 : ptr_q + KW'(1);
    st_d     = cur_st;
    cnt_d    = cur_cnt;
    push     = 1'b0;
    push_rpt = 1'b0;
    case (cur_st)
      IDLE: begin
        if (lvl) begin
          push  = 1'b1;
          cnt_d = '0;
          st_d  = (REPEAT_DELAY == 0) ? HELD : DELAY;
        end
      end
      DELAY: begin
        if (fell) begin
          st_d = IDLE;
        end else if (cur_cnt == DELAY_LAST) begin
          push     = 1'b1;
          push_rpt = 1'b1;
          cnt_d    = '0;
          st_d     = REPEAT;
        end else begin
          cnt_d = cur_cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (fell) begin
          st_d = IDLE;
        end else if (cur_cnt == PERIOD_LAST) begin
          push     = 1'b1;
          push_rpt = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cur_cnt + CW'(1);
        end
      end
      HELD: begin
        if (fell) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    push_ev     = '0;
    push_ev.key = KEY_IDX_W'(ptr_q);
    push_ev.rpt = push_rpt;
`ifdef KEY_RELEASE_EVENT_EN
    if (fell && (cur_st != IDLE)) begin
      push        = 1'b1;
      push_ev.rel = 1'b1;
    end
`endif
    pop = o_Valid & i_Ready;
  end

  // Scan pointer and the scanned key's state, counter and last level.
  always_ff @(negedge i_Clk) begin
    if (i_Rst) begin
      ptr_q  <= '0;
      prev_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        st_q[k]  <= IDLE;
        cnt_q[k] <= '0;
      end
    end else begin
      ptr_q          <= ptr_d;
      st_q[ptr_q]    <= st_d;
      cnt_q[ptr_q]   <= cnt_d;
      prev_q[ptr_q]  <= lvl;
    end
  end

  key_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_Clk),
    .rst_i     (i_Rst),
    .push_i    (push),
    .data_i    (push_ev),
    .pop_i     (pop),
    .valid_o   (o_Valid),
    .data_o    (head_ev),
    .overflow_o(o_Overflow)
  );

  assign o_Key    = KW'(head_ev.key);
  assign o_Repeat = head_ev.rpt;
`ifdef KEY_RELEASE_EVENT_EN
  assign o_Release = head_ev.rel;
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: directed scenarios, a vector table and a randomized run against a model.
// Latency: events expected at the head right after the falling edge that scans the key.
// Backpressure: i_Ready driven both steady and randomly, including long stalls to force drops.
module tb_key_event_scheduler;

  localparam int NK = 4;
  localparam int RD = 3;
  localparam int RP = 2;
  localparam int FD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = '0;
  logic       ready = 1'b1;
  logic       valid, orpt, oovf;
  logic [1:0] okey;
  logic [3:0] keys_b = '0;
  logic       ready_b = 1'b1;
  logic       valid_b, rpt_b, ovf_b;
  logic [1:0] key_b;
`ifdef KEY_RELEASE_EVENT_EN
  logic       rel_a, rel_b;
`endif

  always #5 clk = ~clk;

  key_event_scheduler #(.NUM_KEYS(NK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(FD)) u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Keys(keys), .o_Valid(valid), .i_Ready(ready),
    .o_Key(okey), .o_Repeat(orpt), .o_Overflow(oovf)
`ifdef KEY_RELEASE_EVENT_EN
    , .o_Release(rel_a)
`endif
  );

  key_event_scheduler #(.NUM_KEYS(NK), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP), .FIFO_DEPTH(FD)) u_dut_norpt (
    .i_Clk(clk), .i_Rst(rst), .i_Keys(keys_b), .o_Valid(valid_b), .i_Ready(ready_b),
    .o_Key(key_b), .o_Repeat(rpt_b), .o_Overflow(ovf_b)
`ifdef KEY_RELEASE_EVENT_EN
    , .o_Release(rel_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: events derived from how many consecutive scans each key has been seen pressed.
  typedef struct { int key; bit rpt; bit rel; } mev_t;
  mev_t q[$];
  int   nh[NK];
  int   mcyc;
  bit   m_ovf;

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < NK; k++) nh[k] = 0;
    mcyc  = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    int   p;
    bit   has_ev;
    bit   pop;
    bit   full;
    mev_t ev;
    p      = mcyc % NK;
    mcyc++;
    has_ev = 0;
    ev.key = p; ev.rpt = 0; ev.rel = 0;
    if (keys[p]) begin
      if (nh[p] == 0) has_ev = 1;
      else if (RD > 0 && nh[p] >= RD && ((nh[p] - RD) % RP) == 0) begin
        has_ev = 1; ev.rpt = 1;
      end
      nh[p]++;
    end else begin
`ifdef KEY_RELEASE_EVENT_EN
      if (nh[p] > 0) begin has_ev = 1; ev.rel = 1; end
`endif
      nh[p] = 0;
    end
    pop   = (q.size() > 0) && ready;
    full  = (q.size() == FD);
    m_ovf = has_ev && full && !pop;
    if (pop) void'(q.pop_front());
    if (has_ev && !m_ovf) q.push_back(ev);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] k);
    keys = k;
    rst  = 1'b1;
    repeat (3) tick();
    chk("rst_valid", valid, 0);
    chk("rst_key", okey, 0);
    chk("rst_repeat", orpt, 0);
    chk("rst_overflow", oovf, 0);
    chk("rst_valid_b", valid_b, 0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct { bit rst; logic [3:0] keys; bit rdy; bit ev; int ek; bit er; bit eo; } vec_t;
  vec_t vt[13];

  int ev_edge[$];
  int ev_key[$];
  int ev_rpt[$];
  int cnt;
  int last_key;
  int exp_edge[5];
  int exp_rpt[5];

  initial begin
    // Tests 4 (stall, drop key 2) and 5 (full queue, simultaneous pop and push).
    vt[0]  = '{1, 4'b0111, 0, 1, 0, 0, 0};
    vt[1]  = '{0, 4'b0111, 0, 1, 0, 0, 0};
    vt[2]  = '{0, 4'b0111, 0, 1, 0, 0, 1};
    vt[3]  = '{0, 4'b0111, 0, 1, 0, 0, 0};
    vt[4]  = '{0, 4'b0111, 0, 1, 0, 0, 0};
    vt[5]  = '{0, 4'b0111, 0, 1, 0, 0, 0};
    vt[6]  = '{0, 4'b0111, 1, 1, 1, 0, 0};
    vt[7]  = '{0, 4'b0111, 1, 0, 0, 0, 0};
    vt[8]  = '{1, 4'b0111, 0, 1, 0, 0, 0};
    vt[9]  = '{0, 4'b0111, 0, 1, 0, 0, 0};
    vt[10] = '{0, 4'b0111, 1, 1, 1, 0, 0};
    vt[11] = '{0, 4'b0111, 1, 1, 2, 0, 0};
    vt[12] = '{0, 4'b0111, 1, 0, 0, 0, 0};
    exp_edge = '{2, 14, 22, 30, 38};
    exp_rpt  = '{0, 1, 1, 1, 1};

    // Test 1: key 1 held through reset gives a fresh press, then silence until the first repeat.
    ready = 1'b1;
    do_reset(4'b0010);
    tick();
    chk("t1_edge0_valid", valid, 0);
    tick();
    chk("t1_press_valid", valid, 1);
    chk("t1_press_key", okey, 1);
    chk("t1_press_repeat", orpt, 0);
    cnt = 0;
    for (int e = 2; e <= 12; e++) begin
      tick();
      if (valid) cnt++;
    end
    chk("t1_quiet_cycles", cnt, 0);
    tick();
    chk("t1_repeat_valid", valid, 1);
    chk("t1_repeat_key", okey, 1);
    chk("t1_repeat_flag", orpt, 1);

    // Test 2: hold key 2 for 10 rounds; press at round 0, repeats at rounds 3,5,7,9, then nothing.
    do_reset(4'b0000);
    keys = 4'b0100;
    ev_edge.delete(); ev_key.delete(); ev_rpt.delete();
    for (int e = 0; e < 72; e++) begin
      if (e == 40) keys = 4'b0000;
      tick();
      if (valid) begin
        ev_edge.push_back(e); ev_key.push_back(okey); ev_rpt.push_back(orpt);
      end
    end
    chk("t2_event_count", ev_edge.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < ev_edge.size()) begin
        chk($sformatf("t2_ev%0d_edge", i), ev_edge[i], exp_edge[i]);
        chk($sformatf("t2_ev%0d_key", i), ev_key[i], 2);
        chk($sformatf("t2_ev%0d_repeat", i), ev_rpt[i], exp_rpt[i]);
      end
    end

    // Test 3: keys 0 and 3 pressed together; key 0 event leads key 3 by three cycles.
    do_reset(4'b0000);
    keys = 4'b1001;
    ev_edge.delete(); ev_key.delete(); ev_rpt.delete();
    for (int e = 0; e < 8; e++) begin
      tick();
      if (valid) begin
        ev_edge.push_back(e); ev_key.push_back(okey); ev_rpt.push_back(orpt);
      end
    end
    chk("t3_event_count", ev_edge.size(), 2);
    if (ev_edge.size() >= 2) begin
      chk("t3_first_key", ev_key[0], 0);
      chk("t3_second_key", ev_key[1], 3);
      chk("t3_gap_cycles", ev_edge[1] - ev_edge[0], 3);
    end
    keys = 4'b0000;

    // Tests 4 and 5 from the vector table.
    for (int i = 0; i < 13; i++) begin
      if (vt[i].rst) do_reset(4'b0000);
      keys  = vt[i].keys;
      ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_key", i), okey, vt[i].ek);
        chk($sformatf("vec%0d_repeat", i), orpt, vt[i].er);
      end
      chk($sformatf("vec%0d_overflow", i), oovf, vt[i].eo);
    end
    keys  = 4'b0000;
    ready = 1'b1;

    // Test 6: auto-repeat disabled; a long hold gives exactly one press (plus a release when enabled).
    keys_b   = 4'b0010;
    ready_b  = 1'b1;
    cnt      = 0;
    last_key = -1;
    for (int e = 0; e < 80; e++) begin
      tick();
      if (valid_b) begin
        cnt++;
        last_key = key_b;
        chk("t6_press_repeat", rpt_b, 0);
      end
    end
    chk("t6_press_count", cnt, 1);
    chk("t6_press_key", last_key, 1);
    keys_b = 4'b0000;
    cnt    = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (valid_b) begin
        cnt++;
        chk("t6_release_key", key_b, 1);
`ifdef KEY_RELEASE_EVENT_EN
        chk("t6_release_flag", rel_b, 1);
`endif
      end
    end
`ifdef KEY_RELEASE_EVENT_EN
    chk("t6_release_count", cnt, 1);
`else
    chk("t6_release_count", cnt, 0);
`endif

    // Randomized run against the reference model, with periodic stalls and a mid-run reset.
    do_reset(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1560) do_reset(keys);
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 23) == 0) keys[k] = ~keys[k];
      ready = ((c % 256) < 48) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
      model_edge();
      chk("rnd_valid", valid, (q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_key", okey, q[0].key);
        chk("rnd_repeat", orpt, q[0].rpt);
`ifdef KEY_RELEASE_EVENT_EN
        chk("rnd_release", rel_a, q[0].rel);
`endif
      end
      chk("rnd_overflow", oovf, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
